// File: rtl/pio_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pio_pattern_sequencer
// Purpose  : Plays an 8-entry LED pattern table into an 8-bit GPIO PIO by
//            issuing single-cycle Avalon-MM writes to PIO register 0 on a
//            programmable cadence, without host involvement.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n        system clock; asynchronous active-low reset
//   address[1:0]        CSR word address (0 CTRL, 1 PERIOD, 2 PATTERN, 3 LENGTH)
//   chipselect,write_n  CSR write when chipselect && !write_n
//   writedata[31:0]     CSR write data
//   readdata[31:0]      CSR read data, combinational from address
//   m_address[1:0]      PIO address, always 0
//   m_chipselect        PIO select, high only in the strobe cycle
//   m_write_n           PIO write strobe, active-low
//   m_writedata[31:0]   {24'b0, pattern} during the strobe, 0 otherwise
//   busy                high while the sequencer is running
// ============================================================================
module pio_pattern_sequencer #(
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                oneshot_q, oneshot_d;
  logic                done_q, done_d;

  logic [PERIOD_W-1:0] period_q;
  logic [2:0]          length_q;
  logic [7:0]          table_q [8];

  logic                csr_wr;
  logic                ctrl_wr;
  logic                start;
  logic                stop;
  logic                expire;
  logic                strobe;
  logic [PERIOD_W-1:0] period_eff;
  logic                unused_wdata;

  assign csr_wr  = chipselect && !write_n;
  assign ctrl_wr = csr_wr && (address == 2'd0);

  // EN=0 always wins over RESTART in the same write.
  assign stop  = ctrl_wr && !writedata[0];
  // A run starts on an EN rising edge, or on RESTART with EN=1 from any state.
  assign start = ctrl_wr && writedata[0] && (writedata[2] || !en_q);

  // A programmed period of 0 behaves exactly like 1 (strobe every cycle).
  assign period_eff = (period_q == '0) ? PERIOD_W'(1) : period_q;

  // Not every writedata bit is decoded for every PERIOD_W.
  assign unused_wdata = ^writedata;

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      length_q <= '0;
      for (int i = 0; i < 8; i++) begin
        table_q[i] <= '0;
      end
    end else if (csr_wr) begin
      case (address)
        2'd1:    period_q <= writedata[PERIOD_W-1:0];
        2'd2:    table_q[writedata[18:16]] <= writedata[7:0];
        2'd3:    length_q <= writedata[2:0];
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      done_q    <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    oneshot_d = oneshot_q;
    done_d    = done_q;
    expire    = 1'b0;

    if (ctrl_wr) begin
      en_d      = writedata[0];
      oneshot_d = writedata[1];
    end

    case (state_q)
      S_LOAD: begin
        // cnt holds the number of DWELL cycles that follow this strobe.
        cnt_d = period_eff - PERIOD_W'(1);
        if (period_eff == PERIOD_W'(1)) begin
          expire = 1'b1;
        end else begin
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt_q <= PERIOD_W'(1)) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: ;
    endcase

    if (expire) begin
      if (oneshot_q && (step_q == length_q)) begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        done_d  = 1'b1;
      end else begin
        // ">=" also catches LENGTH having been lowered below the current step.
        step_d  = (step_q >= length_q) ? 3'd0 : step_q + 3'd1;
        state_d = S_LOAD;
      end
    end

    // Host control overrides whatever the sequencer was about to do.
    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_LOAD;
      step_d  = '0;
      en_d    = 1'b1;
      done_d  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign strobe       = (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign m_address    = 2'd0;
  assign m_chipselect = strobe;
  assign m_write_n    = !strobe;
  // The table is read in the strobe cycle itself, so a same-cycle PATTERN
  // write to this step lands after the PIO has taken the old value.
  assign m_writedata  = strobe ? {24'b0, table_q[step_q]} : 32'b0;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {22'b0, done_q, busy, 5'b0, 1'b0, oneshot_q, en_q};
      2'd1: readdata[PERIOD_W-1:0] = period_q;
      2'd2: readdata = {13'b0, step_q, 8'b0, table_q[step_q]};
      2'd3: readdata = {29'b0, length_q};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_pattern_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pio_pattern_sequencer
// Purpose  : Self-checking bench for pio_pattern_sequencer. CSR accesses come
//            from a vector table; PIO strobes are matched against a queue of
//            expected {cycle, pattern} entries.
// Revision : 1.0  initial release
// ============================================================================
module tb_pio_pattern_sequencer;

  localparam int PERIOD_W = 24;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        busy;

  pio_pattern_sequencer #(.PERIOD_W(PERIOD_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } strobe_t;
  strobe_t sb[$];

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] rexp;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    strobe_t e;
    if (m_chipselect || !m_write_n) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got data 0x%02h at cycle %0d, expected none",
                 m_writedata[7:0], cyc);
      end else begin
        e = sb.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("strobe_data", m_writedata, {24'b0, e.data});
        chk("strobe_ctl", {28'b0, m_address, m_chipselect, m_write_n}, 32'h2);
      end
    end
  end

  task automatic push(input int c, input logic [7:0] d);
    strobe_t s;
    s.cyc  = c;
    s.data = d;
    sb.push_back(s);
  endtask

  // Write sampled at the next rising edge; t returns that edge's cycle number.
  task automatic csr_write(input logic [1:0] a, input logic [31:0] d, output int t);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    t          = cyc;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic csr_write_at(input int e, input logic [1:0] a, input logic [31:0] d);
    int t;
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
    csr_write(a, d, t);
    chk("write_edge", 32'(t), 32'(e));
  endtask

  task automatic at_neg(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic check_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  task automatic drain(input int c);
    at_neg(c);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chipselect", {31'b0, m_chipselect}, 32'd0);
    chk("rst_write_n", {31'b0, m_write_n}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_maddr_wdata", {m_writedata[29:0], m_address}, 32'd0);
    for (int a = 0; a < 4; a++) check_rd(2'(a), 32'd0, $sformatf("rst_rd%0d", a));

    // ---------------- CSR vector table ----------------
    vecs[0] = '{2'd1, 32'h0012_3456, 2'd1, 32'h0012_3456};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 2'd1, 32'h00FF_FFFF};
    vecs[2] = '{2'd3, 32'hFFFF_FFFD, 2'd3, 32'h0000_0005};
    vecs[3] = '{2'd3, 32'h0000_0003, 2'd3, 32'h0000_0003};
    vecs[4] = '{2'd2, 32'h0000_005A, 2'd2, 32'h0000_005A};
    vecs[5] = '{2'd2, 32'h0003_0033, 2'd2, 32'h0000_005A};
    vecs[6] = '{2'd2, 32'hFFF8_01C3, 2'd2, 32'h0000_00C3};
    vecs[7] = '{2'd0, 32'h0000_0002, 2'd0, 32'h0000_0002};
    vecs[8] = '{2'd0, 32'h0000_0004, 2'd0, 32'h0000_0000};
    vecs[9] = '{2'd0, 32'hFFFF_FFF8, 2'd0, 32'h0000_0000};
    for (int i = 0; i < 10; i++) begin
      csr_write(vecs[i].waddr, vecs[i].wdata, t);
      check_rd(vecs[i].raddr, vecs[i].rexp, $sformatf("csr_vec%0d", i));
    end
    drain(cyc + 3);

    // ---------------- continuous loop ----------------
    csr_write(2'd2, 32'h0000_0001, t);
    csr_write(2'd2, 32'h0001_0002, t);
    csr_write(2'd2, 32'h0002_0004, t);
    csr_write(2'd2, 32'h0003_0008, t);
    csr_write(2'd3, 32'd3, t);
    csr_write(2'd1, 32'd5, t);
    csr_write(2'd0, 32'h1, t);
    for (int i = 0; i < 8; i++) push(t + 5 * i, 8'(1 << (i % 4)));
    check_rd(2'd0, 32'h0000_0101, "loop_ctrl_running");
    csr_write_at(t + 7, 2'd0, 32'h1);
    at_neg(t + 12);
    check_rd(2'd2, 32'h0002_0004, "loop_step2_rd");
    at_neg(t + 36);
    chk("loop_busy_before_stop", {31'b0, busy}, 32'd1);
    csr_write_at(t + 37, 2'd0, 32'h0);
    at_neg(t + 37);
    chk("loop_busy_after_stop", {31'b0, busy}, 32'd0);
    drain(t + 50);

    // ---------------- one-shot ----------------
    csr_write(2'd3, 32'd1, t);
    csr_write(2'd1, 32'd3, t);
    csr_write(2'd0, 32'h3, t);
    push(t, 8'h01);
    push(t + 3, 8'h02);
    at_neg(t + 5);
    chk("oneshot_busy_last", {31'b0, busy}, 32'd1);
    at_neg(t + 6);
    chk("oneshot_busy_idle", {31'b0, busy}, 32'd0);
    check_rd(2'd0, 32'h0000_0202, "oneshot_ctrl_done");
    check_rd(2'd2, 32'h0001_0002, "oneshot_step_hold");
    drain(t + 15);

    // ---------------- PERIOD=0, LENGTH=0 ----------------
    csr_write(2'd1, 32'd0, t);
    csr_write(2'd3, 32'd0, t);
    csr_write(2'd2, 32'h0000_00AA, t);
    csr_write(2'd0, 32'h1, t);
    for (int i = 0; i < 6; i++) push(t + i, 8'hAA);
    check_rd(2'd0, 32'h0000_0101, "p0_done_cleared");
    csr_write_at(t + 6, 2'd0, 32'h0);
    drain(t + 15);
    check_rd(2'd0, 32'h0000_0000, "p0_ctrl_stopped");

    // ---------------- restart and collisions ----------------
    csr_write(2'd2, 32'h0000_0011, t);
    csr_write(2'd2, 32'h0001_0022, t);
    csr_write(2'd2, 32'h0002_0033, t);
    csr_write(2'd3, 32'd3, t);
    csr_write(2'd1, 32'd4, t);
    csr_write(2'd0, 32'h1, t);
    push(t,      8'h11);
    push(t + 4,  8'h22);
    push(t + 8,  8'h33);
    push(t + 10, 8'h11);  // restart from step 2
    push(t + 14, 8'h22);  // old value despite coincident PATTERN write
    push(t + 18, 8'h33);
    push(t + 22, 8'h08);
    push(t + 26, 8'h11);
    push(t + 30, 8'h99);  // new value on next visit
    push(t + 34, 8'h11);  // LENGTH lowered below step -> wrap to 0
    push(t + 38, 8'h11);  // PERIOD change applies from this LOAD
    push(t + 40, 8'h11);
    csr_write_at(t + 10, 2'd0, 32'h5);
    csr_write_at(t + 15, 2'd2, 32'h0001_0099);
    csr_write_at(t + 32, 2'd3, 32'd0);
    csr_write_at(t + 36, 2'd1, 32'd2);
    csr_write_at(t + 41, 2'd0, 32'h4);  // EN=0 with RESTART: stop wins
    at_neg(t + 41);
    chk("restart_stop_busy", {31'b0, busy}, 32'd0);
    drain(t + 55);
    check_rd(2'd0, 32'h0000_0000, "restart_stop_ctrl");

    // ---------------- asynchronous reset mid-strobe ----------------
    csr_write(2'd0, 32'h1, t);
    push(t, 8'h11);
    at_neg(t);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_chipselect", {31'b0, m_chipselect}, 32'd0);
    chk("arst_write_n", {31'b0, m_write_n}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    check_rd(2'd0, 32'd0, "arst_rd_ctrl");
    check_rd(2'd1, 32'd0, "arst_rd_period");
    check_rd(2'd2, 32'd0, "arst_rd_pattern");
    @(negedge clk);
    reset_n = 1'b1;
    drain(cyc + 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
